serial_ripple_subtractor: RTL and testbench

- Bit-serial subtractor: computes DIFF = A - B - bin using one full-subtractor cell iterated LSB-first, one bit per clock, with a rippled borrow register.
- The inverse of the team's parallel ripple adder. Trades latency (WIDTH cycles) for a single bit-cell.
- Sits in the arithmetic library behind a valid/ready pair on each side, so it drops into datapaths between registered stages.

---
 rtl/serial_ripple_subtractor.sv | 164 ++++++++++++++++
 tb/tb_serial_ripple_subtractor.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial subtractor: DIFF = A - B - bin, one full-subtractor bit per clock, LSB first.
// Optional signed-overflow flag enabled by defining SUB_SIGNED_OVF_EN.
module serial_ripple_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy
`ifdef SUB_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             last;
  logic             a0;
  logic             b0;
  logic             d;
  logic             br_next;
  logic [WIDTH-1:0] res_next;

`ifdef SUB_SIGNED_OVF_EN
  logic             a_msb;
  logic             b_msb;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and the single full-subtractor cell
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last       = 1'b0;
    a0         = a_sr[0];
    b0         = b_sr[0];
    d          = a0 ^ b0 ^ br;
    br_next    = (~a0 & b0) | (~(a0 ^ b0) & br);
    res_next   = {d, res_sr[WIDTH-1:1]};

    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == CW'(WIDTH - 1)) begin
          last       = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_valid && out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Handshake/status flags registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
      busy      <= (state_next != IDLE);
    end
  end

  // Operand/result shift registers, borrow ripple and bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      br     <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sr   <= a;
      b_sr   <= b;
      res_sr <= '0;
      br     <= bin;
      cnt    <= '0;
    end else if (state == SHIFT) begin
      a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
      res_sr <= res_next;
      br     <= br_next;
      cnt    <= cnt + CW'(1);
    end
  end

  // Visible result only changes when a complete difference is ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff <= '0;
      bout <= 1'b0;
    end else if (last) begin
      diff <= res_next;
      bout <= br_next;
    end
  end

`ifdef SUB_SIGNED_OVF_EN
  // Operand sign bits are shifted out, so keep a copy for the overflow test
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (accept) begin
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1];
      end
      if (last) begin
        ovf <= (a_msb != b_msb) && (d != a_msb);
      end
    end
  end
`endif

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Randomized self-checking bench for serial_ripple_subtractor against an integer-arithmetic model.
module tb_serial_ripple_subtractor;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         busy;
`ifdef SUB_SIGNED_OVF_EN
  logic         ovf;
`endif

  int n_vec;
  int n_err;

  serial_ripple_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .busy      (busy)
`ifdef SUB_SIGNED_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One full transaction: accept, W shift cycles, optional back-pressure, drain
  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic obin,
                        input int hold, input bit noise);
    int           sd;
    logic [W-1:0] ed;
    logic         eb;
    sd = int'(oa) - int'(ob) - int'(obin);
    ed = W'(sd);
    eb = (sd < 0);

    @(negedge clk);
    chk("in_ready_idle", 64'(in_ready), 64'(1));
    a = oa; b = ob; bin = obin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    chk("no_valid_e0", 64'(out_valid), 64'(0));
    for (int k = 1; k < int'(W); k++) begin
      in_valid = noise ? 1'($urandom) : 1'b0;
      @(posedge clk); #1;
      chk("no_early_valid", 64'(out_valid), 64'(0));
    end
    in_valid = noise ? 1'($urandom) : 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("latency_valid", 64'(out_valid), 64'(1));
    chk("diff", 64'(diff), 64'(ed));
    chk("bout", 64'(bout), 64'(eb));
    chk("in_ready_done", 64'(in_ready), 64'(0));
    chk("busy_done", 64'(busy), 64'(1));
`ifdef SUB_SIGNED_OVF_EN
    chk("ovf", 64'(ovf), 64'((oa[W-1] != ob[W-1]) && (ed[W-1] != oa[W-1])));
`endif
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", 64'(out_valid), 64'(1));
      chk("hold_diff", 64'(diff), 64'(ed));
      chk("hold_bout", 64'(bout), 64'(eb));
      chk("hold_in_ready", 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("drain_valid", 64'(out_valid), 64'(0));
    chk("drain_in_ready", 64'(in_ready), 64'(1));
    chk("drain_busy", 64'(busy), 64'(0));
    chk("drain_diff_held", 64'(diff), 64'(ed));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0; b = '0; bin = 1'b0;

    #12;
    chk("rst_diff", 64'(diff), 64'(0));
    chk("rst_bout", 64'(bout), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
`ifdef SUB_SIGNED_OVF_EN
    chk("rst_ovf", 64'(ovf), 64'(0));
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 64'(in_ready), 64'(1));

    run_op(4'd9, 4'd3, 1'b0, 0, 1'b0);
    run_op(4'd3, 4'd9, 1'b0, 0, 1'b0);
    run_op(4'd0, 4'd0, 1'b1, 0, 1'b0);
    run_op(4'd15, 4'd15, 1'b0, 0, 1'b0);
    run_op(4'd12, 4'd5, 1'b0, 10, 1'b1);

    // Asynchronous reset while bit 2 is being shifted
    @(negedge clk);
    a = 4'd9; b = 4'd3; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_diff", 64'(diff), 64'(0));
    chk("abort_bout", 64'(bout), 64'(0));
    chk("abort_out_valid", 64'(out_valid), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk("abort_no_stale", 64'(out_valid), 64'(0));
    end
    run_op(4'd5, 4'd2, 1'b0, 0, 1'b0);

    run_op(4'd7, 4'd8, 1'b0, 0, 1'b0);
    run_op(4'd8, 4'd1, 1'b0, 0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
